// File: rtl/read_buffer_pl.sv
// Single-line read buffer in front of the CCI read channel.
// Word hits come from the buffered line; misses and direct reads fetch one tagged line.
module read_buffer_pl #(
  parameter int unsigned ADDR_LMT    = 20,
  parameter int unsigned MDATA       = 14,
  parameter int unsigned CACHE_WIDTH = 512,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [ADDR_LMT-1:0]              rd_req_addr,
  output logic [MDATA-1:0]                 rd_req_mdata,
  output logic                             rd_req_en,
  input  logic                             rd_req_almostfull,
  input  logic                             rd_rsp_valid,
  input  logic [MDATA-1:0]                 rd_rsp_mdata,
  input  logic [CACHE_WIDTH-1:0]           rd_rsp_data,
  input  logic [ADDR_LMT+$clog2(CACHE_WIDTH/DATA_WIDTH)-1:0] rd_addr,
  input  logic [MDATA-1:0]                 rd_mdata,
  input  logic                             rd_en,
  input  logic                             rd_direct,
  input  logic                             rd_inval,
  output logic                             rd_ready,
  output logic                             rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic [CACHE_WIDTH-1:0]           rd_line,
  output logic                             rd_drop
);

  localparam int unsigned WORDS = CACHE_WIDTH / DATA_WIDTH;
  localparam int unsigned OFF_W = $clog2(WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t                   state, state_n;
  logic                     line_valid, line_valid_n;
  logic [ADDR_LMT-1:0]      tag, tag_n;
  logic [CACHE_WIDTH-1:0]   line_buf, line_buf_n;
  logic [ADDR_LMT-1:0]      pend_addr, pend_addr_n;
  logic [OFF_W-1:0]         pend_off, pend_off_n;
  logic [MDATA-1:0]         pend_mdata, pend_mdata_n;
  logic                     pend_direct, pend_direct_n;
  logic                     no_alloc, no_alloc_n;

  logic [ADDR_LMT-1:0]      req_addr_n;
  logic [MDATA-1:0]         req_mdata_n;
  logic                     req_en_n;
  logic                     ready_n, valid_n, drop_n;
  logic [DATA_WIDTH-1:0]    data_n;
  logic [CACHE_WIDTH-1:0]   line_n;

  logic [ADDR_LMT-1:0]      cmd_line;
  logic [OFF_W-1:0]         cmd_off;

  assign cmd_line = rd_addr[ADDR_LMT+OFF_W-1:OFF_W];
  assign cmd_off  = rd_addr[OFF_W-1:0];

  function automatic logic [DATA_WIDTH-1:0] word_sel(input logic [CACHE_WIDTH-1:0] ln,
                                                     input logic [OFF_W-1:0] off);
    return ln[off*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    state_n       = state;
    line_valid_n  = line_valid;
    tag_n         = tag;
    line_buf_n    = line_buf;
    pend_addr_n   = pend_addr;
    pend_off_n    = pend_off;
    pend_mdata_n  = pend_mdata;
    pend_direct_n = pend_direct;
    no_alloc_n    = no_alloc;
    req_addr_n    = rd_req_addr;
    req_mdata_n   = rd_req_mdata;
    req_en_n      = 1'b0;
    ready_n       = rd_ready;
    valid_n       = 1'b0;
    drop_n        = 1'b0;
    data_n        = rd_data;
    line_n        = rd_line;

    if (rd_inval) line_valid_n = 1'b0;
    if (rd_en && !rd_ready) drop_n = 1'b1;

    case (state)
      ST_IDLE: begin
        if (rd_en) begin
          // A same-cycle invalidate forces a refetch even when the tag matches
          if (!rd_direct && line_valid && !rd_inval && tag == cmd_line) begin
            valid_n = 1'b1;
            data_n  = word_sel(line_buf, cmd_off);
            line_n  = line_buf;
          end else begin
            pend_addr_n   = cmd_line;
            pend_off_n    = cmd_off;
            pend_mdata_n  = rd_mdata;
            pend_direct_n = rd_direct;
            ready_n       = 1'b0;
            state_n       = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (rd_inval) no_alloc_n = 1'b1;
        if (!rd_req_almostfull) begin
          req_en_n    = 1'b1;
          req_addr_n  = pend_addr;
          req_mdata_n = pend_mdata;
          state_n     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rd_inval) no_alloc_n = 1'b1;
        if (rd_rsp_valid && rd_rsp_mdata == pend_mdata) begin
          valid_n    = 1'b1;
          line_n     = rd_rsp_data;
          data_n     = word_sel(rd_rsp_data, pend_off);
          ready_n    = 1'b1;
          no_alloc_n = 1'b0;
          state_n    = ST_IDLE;
          if (!pend_direct && !no_alloc && !rd_inval) begin
            line_buf_n   = rd_rsp_data;
            tag_n        = pend_addr;
            line_valid_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        ready_n = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      line_valid   <= 1'b0;
      tag          <= '0;
      line_buf     <= '0;
      pend_addr    <= '0;
      pend_off     <= '0;
      pend_mdata   <= '0;
      pend_direct  <= 1'b0;
      no_alloc     <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_mdata <= '0;
      rd_req_en    <= 1'b0;
      rd_ready     <= 1'b1;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_line      <= '0;
      rd_drop      <= 1'b0;
    end else begin
      state        <= state_n;
      line_valid   <= line_valid_n;
      tag          <= tag_n;
      line_buf     <= line_buf_n;
      pend_addr    <= pend_addr_n;
      pend_off     <= pend_off_n;
      pend_mdata   <= pend_mdata_n;
      pend_direct  <= pend_direct_n;
      no_alloc     <= no_alloc_n;
      rd_req_addr  <= req_addr_n;
      rd_req_mdata <= req_mdata_n;
      rd_req_en    <= req_en_n;
      rd_ready     <= ready_n;
      rd_valid     <= valid_n;
      rd_data      <= data_n;
      rd_line      <= line_n;
      rd_drop      <= drop_n;
    end
  end

endmodule

// File: tb/tb_read_buffer_pl.sv
// Self-checking bench for read_buffer_pl: directed table, hand sequences, random reads vs a line-cache model.
module tb_read_buffer_pl;

  logic          clk = 1'b0;
  logic          rst;
  logic [19:0]   rd_req_addr;
  logic [13:0]   rd_req_mdata;
  logic          rd_req_en;
  logic          rd_req_almostfull;
  logic          rd_rsp_valid;
  logic [13:0]   rd_rsp_mdata;
  logic [511:0]  rd_rsp_data;
  logic [23:0]   rd_addr;
  logic [13:0]   rd_mdata;
  logic          rd_en, rd_direct, rd_inval;
  logic          rd_ready, rd_valid, rd_drop;
  logic [31:0]   rd_data;
  logic [511:0]  rd_line;

  read_buffer_pl dut (
    .clk(clk), .rst(rst),
    .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
    .rd_req_almostfull(rd_req_almostfull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
    .rd_addr(rd_addr), .rd_mdata(rd_mdata), .rd_en(rd_en), .rd_direct(rd_direct),
    .rd_inval(rd_inval), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_line(rd_line), .rd_drop(rd_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] la;
    logic [3:0]  off;
    bit          dir;
    bit          inv;
    logic [13:0] tg;
    int          bp;
    bit          inv_wait;
    bit          noise;
    bit          exp_miss;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: what the single buffered line should hold
  bit           m_valid;
  logic [19:0]  m_tag;
  logic [511:0] m_line;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] get_line(input logic [19:0] la);
    logic [511:0] l;
    for (int i = 0; i < 16; i++)
      l[i*32 +: 32] = {la[11:0], 4'(i), 16'hA5C3} ^ (32'(i) * 32'h9E3779B9);
    if (la == 20'd5) l[3*32 +: 32] = 32'hDEADBEEF;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_read(input vec_t v);
    logic [511:0] ln;
    int pulses;
    int first;
    ln = get_line(v.la);
    if (v.inv) m_valid = 0;
    rd_addr = {v.la, v.off}; rd_mdata = v.tg; rd_direct = v.dir; rd_inval = v.inv; rd_en = 1'b1;
    tick();
    rd_en = 1'b0; rd_inval = 1'b0; rd_direct = 1'b0;
    if (!v.exp_miss) begin
      chk("hit_valid", rd_valid, 1'b1);
      chk("hit_data", rd_data, m_line[v.off*32 +: 32]);
      chk("hit_line", rd_line, m_line);
      chk("hit_no_req", rd_req_en, 1'b0);
      chk("hit_ready", rd_ready, 1'b1);
      tick();
      chk("hit_pulse", rd_valid, 1'b0);
      return;
    end
    chk("miss_ready", rd_ready, 1'b0);
    chk("miss_no_valid", rd_valid, 1'b0);
    pulses = 0;
    first  = -1;
    for (int c = 0; c < v.bp + 4; c++) begin
      rd_req_almostfull = (c < v.bp);
      tick();
      if (rd_req_en) begin
        pulses++;
        if (first < 0) first = c;
        chk("req_addr", rd_req_addr, v.la);
        chk("req_mdata", rd_req_mdata, v.tg);
      end
    end
    rd_req_almostfull = 1'b0;
    chk("req_pulses", pulses, 1);
    chk("req_cycle", first, v.bp);
    if (v.noise) begin
      rd_rsp_valid = 1'b1; rd_rsp_mdata = v.tg ^ 14'h33; rd_rsp_data = ~ln;
      rd_en = 1'b1; rd_addr = 24'($urandom);
      tick();
      rd_rsp_valid = 1'b0; rd_en = 1'b0;
      chk("noise_no_valid", rd_valid, 1'b0);
      chk("drop_pulse", rd_drop, 1'b1);
      tick();
      chk("drop_once", rd_drop, 1'b0);
      chk("noise_no_valid2", rd_valid, 1'b0);
    end
    if (v.inv_wait) begin
      rd_inval = 1'b1;
      tick();
      rd_inval = 1'b0;
      m_valid = 0;
    end
    rd_rsp_valid = 1'b1; rd_rsp_mdata = v.tg; rd_rsp_data = ln;
    tick();
    rd_rsp_valid = 1'b0;
    chk("rsp_valid", rd_valid, 1'b1);
    chk("rsp_data", rd_data, ln[v.off*32 +: 32]);
    chk("rsp_line", rd_line, ln);
    chk("rsp_ready", rd_ready, 1'b1);
    tick();
    chk("rsp_pulse", rd_valid, 1'b0);
    chk("rsp_no_req", rd_req_en, 1'b0);
    if (!v.dir && !v.inv_wait) begin
      m_valid = 1; m_tag = v.la; m_line = ln;
    end
  endtask

  vec_t tbl [10];
  vec_t rv;

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rd_req_almostfull = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_mdata = '0;
    rd_rsp_data = '0; rd_addr = '0; rd_mdata = '0; rd_en = 1'b0; rd_direct = 1'b0; rd_inval = 1'b0;
    m_valid = 0; m_tag = '0; m_line = '0;
    repeat (3) tick();
    chk("rst_ready", rd_ready, 1'b1);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_req_en", rd_req_en, 1'b0);
    chk("rst_req_addr", rd_req_addr, 20'd0);
    chk("rst_drop", rd_drop, 1'b0);
    chk("rst_data", rd_data, 32'd0);
    chk("rst_line", rd_line, 512'd0);
    rst = 1'b0;
    tick();

    //        la     off    dir inv tg      bp iw nz miss
    tbl[0] = '{20'd5, 4'd3,  0, 0, 14'h11, 0, 0, 0, 1};
    tbl[1] = '{20'd5, 4'd15, 0, 0, 14'h12, 0, 0, 0, 0};
    tbl[2] = '{20'd6, 4'd2,  0, 0, 14'h13, 4, 0, 0, 1};
    tbl[3] = '{20'd5, 4'd0,  0, 0, 14'h11, 0, 0, 1, 1};
    tbl[4] = '{20'd9, 4'd1,  1, 0, 14'h05, 1, 0, 0, 1};
    tbl[5] = '{20'd5, 4'd7,  0, 0, 14'h06, 0, 0, 0, 0};
    tbl[6] = '{20'd7, 4'd4,  0, 0, 14'h07, 0, 1, 0, 1};
    tbl[7] = '{20'd7, 4'd4,  0, 0, 14'h08, 0, 0, 0, 1};
    tbl[8] = '{20'd7, 4'd9,  0, 1, 14'h09, 0, 0, 0, 1};
    tbl[9] = '{20'd7, 4'd0,  0, 0, 14'h0A, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) run_read(tbl[i]);

    // Reset while a miss is outstanding; the old-tag response must be ignored
    rd_addr = {20'd3, 4'd1}; rd_mdata = 14'h2A; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    chk("mid_req", rd_req_en, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_valid = 0;
    chk("mid_rst_ready", rd_ready, 1'b1);
    chk("mid_rst_req", rd_req_en, 1'b0);
    rd_rsp_valid = 1'b1; rd_rsp_mdata = 14'h2A; rd_rsp_data = get_line(20'd3);
    tick();
    rd_rsp_valid = 1'b0;
    tick();
    chk("stale_rsp_ignored", rd_valid, 1'b0);
    rv = '{20'd7, 4'd2, 0, 0, 14'h2B, 0, 0, 0, 1};
    run_read(rv);

    for (int i = 0; i < 40; i++) begin
      rv.la       = 20'($urandom_range(0, 3));
      rv.off      = 4'($urandom);
      rv.dir      = ($urandom_range(0, 7) == 0);
      rv.inv      = ($urandom_range(0, 7) == 0);
      rv.tg       = 14'($urandom);
      rv.bp       = $urandom_range(0, 2);
      rv.inv_wait = ($urandom_range(0, 7) == 0);
      rv.noise    = ($urandom_range(0, 7) == 0);
      rv.exp_miss = rv.dir || rv.inv || !(m_valid && m_tag == rv.la);
      run_read(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
